// File: rtl/check_node_unit.sv
// Min-sum check node: K sign/magnitude messages in, K extrinsic messages plus row parity out, one register stage.
// Define CNU_OFFSET_EN to build the offset min-sum variant (min1/min2 reduced by 1, floored at 0).
module check_node_unit #(
    parameter int K         = 6,
    parameter int IN_WIDTH  = 6,
    parameter int OUT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [K*IN_WIDTH-1:0]  X,
    output logic [K*OUT_WIDTH-1:0] Y,
    output logic                   p_bit
);

    localparam int MAG_W = OUT_WIDTH - 1;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IN_WIDTH:0] SAT_LIM = (IN_WIDTH + 1)'((2 ** MAG_W) - 1);

    // |x| clipped to the output magnitude range; the extra bit keeps -2^(IN_WIDTH-1) from wrapping.
    function automatic logic [MAG_W-1:0] sat_mag(input logic signed [IN_WIDTH-1:0] x);
        logic signed [IN_WIDTH:0] ext;
        logic        [IN_WIDTH:0] abs_v;
        ext   = {x[IN_WIDTH-1], x};
        abs_v = x[IN_WIDTH-1] ? $unsigned(-ext) : $unsigned(ext);
        return (abs_v > SAT_LIM) ? '1 : abs_v[MAG_W-1:0];
    endfunction

    function automatic logic [MAG_W-1:0] dec_sat(input logic [MAG_W-1:0] m);
        return (m == '0) ? '0 : m - 1'b1;
    endfunction

    logic signed [IN_WIDTH-1:0] x_p0 [K];
    logic [K-1:0]               sgn_p0;
    logic [MAG_W-1:0]           mag_p0 [K];
    logic [MAG_W-1:0]           min1_p0, min2_p0;
    logic [MAG_W-1:0]           min1_o_p0, min2_o_p0;
    logic [IDX_W-1:0]           idx_p0;
    logic                       par_p0;
    logic [K*OUT_WIDTH-1:0]     y_nxt_p0;

    logic [K*OUT_WIDTH-1:0]     y_p1;
    logic                       par_p1;

    // Stage p0: conversion, minimum search, parity and output formatting
    always_comb begin
        for (int i = 0; i < K; i++) begin
            x_p0[i]   = $signed(X[i*IN_WIDTH +: IN_WIDTH]);
            sgn_p0[i] = X[i*IN_WIDTH + IN_WIDTH - 1];
            mag_p0[i] = sat_mag(x_p0[i]);
        end
    end

    always_comb begin
        min1_p0 = mag_p0[0];
        idx_p0  = '0;
        for (int i = 1; i < K; i++) begin
            if (mag_p0[i] < min1_p0) begin
                min1_p0 = mag_p0[i];
                idx_p0  = IDX_W'(i);
            end
        end
        min2_p0 = '1;
        for (int i = 0; i < K; i++) begin
            if ((IDX_W'(i) != idx_p0) && (mag_p0[i] < min2_p0)) begin
                min2_p0 = mag_p0[i];
            end
        end
        par_p0 = ^sgn_p0;
    end

    always_comb begin
`ifdef CNU_OFFSET_EN
        min1_o_p0 = dec_sat(min1_p0);
        min2_o_p0 = dec_sat(min2_p0);
`else
        min1_o_p0 = min1_p0;
        min2_o_p0 = min2_p0;
`endif
    end

    always_comb begin
        logic [MAG_W-1:0] mag_v;
        logic             sgn_v;
        y_nxt_p0 = '0;
        mag_v    = '0;
        sgn_v    = 1'b0;
        for (int i = 0; i < K; i++) begin
            mag_v = (IDX_W'(i) == idx_p0) ? min2_o_p0 : min1_o_p0;
            sgn_v = (mag_v == '0) ? 1'b0 : (par_p0 ^ sgn_p0[i]);
            y_nxt_p0[i*OUT_WIDTH +: OUT_WIDTH] = {sgn_v, mag_v};
        end
    end

    // Stage p1: output registers; reset clears the result in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            y_p1   <= '0;
            par_p1 <= 1'b0;
        end else if (en) begin
            y_p1   <= y_nxt_p0;
            par_p1 <= par_p0;
        end
    end

    assign Y     = y_p1;
    assign p_bit = par_p1;

endmodule

// File: tb/tb_check_node_unit.sv
// Directed table-driven bench for check_node_unit; expectations follow the CNU_OFFSET_EN setting.
module tb_check_node_unit;

    localparam int K  = 6;
    localparam int IW = 6;
    localparam int OW = 5;
    localparam int NV = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [K*IW-1:0]   X;
    logic [K*OW-1:0]   Y;
    logic              p_bit;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [5:0][5:0] x;
        logic [5:0][4:0] y;
        logic            p;
    } vec_t;

    vec_t vecs [NV];

    check_node_unit #(.K(K), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .X     (X),
        .Y     (Y),
        .p_bit (p_bit)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0][5:0] mkx(input int a0, a1, a2, a3, a4, a5);
        logic [5:0][5:0] r;
        r[0] = 6'(a0); r[1] = 6'(a1); r[2] = 6'(a2);
        r[3] = 6'(a3); r[4] = 6'(a4); r[5] = 6'(a5);
        return r;
    endfunction

    function automatic logic [5:0][4:0] mky(input int b0, b1, b2, b3, b4, b5);
        logic [5:0][4:0] r;
        r[0] = 5'(b0); r[1] = 5'(b1); r[2] = 5'(b2);
        r[3] = 5'(b3); r[4] = 5'(b4); r[5] = 5'(b5);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [K*OW-1:0] ey, input logic ep);
        checks++;
        if (Y !== ey || p_bit !== ep) begin
            failures++;
            $display("FAIL %s: got Y=%h p_bit=%b, expected Y=%h p_bit=%b", name, Y, p_bit, ey, ep);
        end
    endtask

    initial begin
        // Vector table: inputs, expected Y elements (sign<<4 | mag), parity
        vecs[0].x = mkx(3, 5, 7, 9, 11, 13);
        vecs[1].x = mkx(10, 10, -4, 10, 10, 10);
        vecs[2].x = mkx(-32, 31, 20, 20, 20, 20);
        vecs[3].x = mkx(6, 6, 6, 6, 6, 6);
        vecs[4].x = mkx(1, 1, 1, 1, 1, 1);
        vecs[5].x = mkx(0, -1, 2, -3, 4, 5);
        vecs[6].x = mkx(-7, 2, -2, 9, -31, 5);
        vecs[7].x = mkx(12, -15, 14, 13, -8, 1);
        vecs[0].p = 1'b0; vecs[1].p = 1'b1; vecs[2].p = 1'b1; vecs[3].p = 1'b0;
        vecs[4].p = 1'b0; vecs[5].p = 1'b0; vecs[6].p = 1'b1; vecs[7].p = 1'b0;
`ifdef CNU_OFFSET_EN
        vecs[0].y = mky(4, 2, 2, 2, 2, 2);
        vecs[1].y = mky(19, 19, 9, 19, 19, 19);
        vecs[2].y = mky(14, 30, 30, 30, 30, 30);
        vecs[3].y = mky(5, 5, 5, 5, 5, 5);
        vecs[4].y = mky(0, 0, 0, 0, 0, 0);
        vecs[5].y = mky(0, 0, 0, 0, 0, 0);
        vecs[6].y = mky(1, 17, 1, 17, 1, 17);
        vecs[7].y = mky(0, 0, 0, 0, 0, 7);
`else
        vecs[0].y = mky(5, 3, 3, 3, 3, 3);
        vecs[1].y = mky(20, 20, 10, 20, 20, 20);
        vecs[2].y = mky(15, 31, 31, 31, 31, 31);
        vecs[3].y = mky(6, 6, 6, 6, 6, 6);
        vecs[4].y = mky(1, 1, 1, 1, 1, 1);
        vecs[5].y = mky(1, 0, 0, 0, 0, 0);
        vecs[6].y = mky(2, 18, 2, 18, 2, 18);
        vecs[7].y = mky(1, 17, 1, 1, 17, 8);
`endif

        // Reset held with en=1 and random input
        reset = 1'b0;
        en    = 1'b1;
        X     = 36'({$urandom(), $urandom()});
        tick();
        check("reset_cycle0", '0, 1'b0);
        X = 36'({$urandom(), $urandom()});
        tick();
        check("reset_cycle1", '0, 1'b0);

        // Release with en=0: output stays cleared, then first en edge yields a result
        reset = 1'b1;
        en    = 1'b0;
        X     = vecs[0].x;
        tick();
        check("post_reset_idle", '0, 1'b0);
        en = 1'b1;
        tick();
        check("vec0", vecs[0].y, vecs[0].p);

        // Back-to-back table vectors, one result per cycle
        for (int i = 1; i < NV; i++) begin
            X = vecs[i].x;
            tick();
            check($sformatf("vec%0d", i), vecs[i].y, vecs[i].p);
        end

        // Tie then hold with en=0 and X=0
        X = vecs[3].x;
        tick();
        check("tie", vecs[3].y, vecs[3].p);
        en = 1'b0;
        X  = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("hold%0d", c), vecs[3].y, vecs[3].p);
        end
        reset = 1'b0;
        tick();
        check("reset_mid_hold", '0, 1'b0);

        // Reset takes priority over en and discards the in-flight result
        reset = 1'b1;
        en    = 1'b1;
        X     = vecs[1].x;
        tick();
        check("restart", vecs[1].y, vecs[1].p);
        reset = 1'b0;
        X     = vecs[2].x;
        tick();
        check("reset_over_en", '0, 1'b0);
        reset = 1'b1;
        en    = 1'b0;
        tick();
        check("idle_after_reset", '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/check_node_unit.md
# check_node_unit

Min-sum check node processor for the array-code LDPC decoder. Each instance serves one row of a parity-check sub-matrix. It takes the K=6 variable-to-check messages delivered by a shuffle network and computes the K check-to-variable messages plus the row's parity bit. Outputs are registered and feed the matching unshuffle network.

## Interface

Parameters:
- K, 6: number of messages (row degree) per check node.
- IN_WIDTH, 6: width of each input message, two's complement.
- OUT_WIDTH, 5: width of each output message, sign-magnitude.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: already decided as synchronous, active-low.
- en, input, 1: process enable, sampled at the rising edge.
- X, input, K×IN_WIDTH packed: input messages; element i occupies bits [6i+5:6i].
- Y, output, K×OUT_WIDTH packed: output messages.
  - Element i occupies bits [5i+4:5i].
  - Bit 4 of each element is the sign; bits 3:0 are the magnitude.
- p_bit, output, 1: row parity, the XOR of all input signs. 0 means the check is satisfied.

## Operation

- Conversion, per input X[i]:
  - s_i = X[i][5].
  - m_i = min(|X[i]|, 15).
  - X[i] = −32 gives m_i = 15.
  - X[i] = 0 gives s_i = 0, m_i = 0.
- Minimum search over m_0..m_5:
  - min1 = smallest magnitude; idx = lowest index holding min1.
  - min2 = smallest magnitude among the indices ≠ idx, so min2 = min1 on a tie.
- Parity: p = s_0 ^ s_1 ^ … ^ s_5.
- Output magnitude: mag_i = min2 when i == idx, otherwise min1.
- Output sign: sign_i = p ^ s_i. If mag_i == 0, sign_i is forced to 0 (no negative zero).
- Y[i] = {sign_i, mag_i}; p_bit = p.
- All arithmetic is unsigned 4-bit after conversion. There is no overflow path.

## Timing

- Latency is 1 cycle. X is sampled at the edge where en=1, and Y and p_bit show the result immediately after that edge.
- When en=0, Y and p_bit hold their last values and X is ignored.
- When reset=0 at a rising edge:
  - Y is cleared to all zeros and p_bit to 0, regardless of en.
  - Reset has priority over en.
  - A reset in the middle of a stream discards the result in flight.
- The first result after reset release comes from the first edge with reset=1 and en=1.
- There is no internal state other than the output registers. Back-to-back en cycles yield one result per cycle.
- There is no handshake; the upstream pipeline registers guarantee that X is stable at the sampling edge.

## Configuration

- Macro `CNU_OFFSET_EN`.
- Defined (offset min-sum):
  - After selection, min1 and min2 are each reduced by 1, saturating at 0.
  - The zero-magnitude sign rule applies after the offset.
  - Latency and p_bit are unchanged.
- Undefined: plain min-sum as described in Operation.

## Test plan

- Reset:
  - Drive reset=0 for 2 cycles with en=1 and X random → Y = 0, p_bit = 0.
  - Release reset → the next en edge produces a valid result.
- Distinct positives:
  - X = {3,5,7,9,11,13} (i = 0..5), en=1 → Y[0] = 5'b00101, Y[1..5] = 5'b00011, p_bit = 0, one cycle later.
- Single negative:
  - X[2] = −4 (6'b111100), all others +10 → Y[2] = 5'b01010, Y[others] = 5'b10100, p_bit = 1.
- Saturation:
  - X[0] = −32, X[1] = +31, others +20 → Y[0] = 5'b01111, Y[1..5] = 5'b11111, p_bit = 1.
- Tie and hold:
  - All X = +6 → all Y = 5'b00110.
  - Then set en=0 and X = {0,…} for 3 cycles → Y and p_bit unchanged.
  - Assert reset mid-hold → Y = 0.
- Offset, with `CNU_OFFSET_EN` defined:
  - Distinct-positives stimulus → Y[0] = 5'b00100, Y[1..5] = 5'b00010.
  - All X = +1 → all Y = 5'b00000.
